// File: rtl/cpu_mem_sys.sv
// Memory subsystem behind the accumulator CPU: unified 2^AW x 16 store,
// two memory-mapped I/O words, and a boot loader that holds the CPU in reset.
module cpu_mem_sys #(
    parameter int              AW          = 10,
    parameter logic [AW-1:0]   IO_OUT_ADDR = 10'h3FF,
    parameter logic [AW-1:0]   IO_IN_ADDR  = 10'h3FE,
    parameter int              HOLD_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_wr,
    input  logic          cpu_addr_mode,
    input  logic [15:0]   cpu_dout,
    output logic [15:0]   cpu_din,
    output logic          cpu_rst,
    input  logic          ld_valid,
    input  logic [15:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic [15:0]   sw_in,
    output logic [15:0]   led_out,
    output logic          led_strobe,
    output logic          run
);

    localparam int CW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES);
    localparam logic [AW-1:0] PTR_MAX   = '1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_HOLD,
        S_RUN
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;
    logic            r_cpu_rst;
    logic            r_ld_ready;
    logic            r_run;
    logic [15:0]     r_led;
    logic            r_strobe;
    logic [15:0]     r_mem [0:(1<<AW)-1];

    logic            w_ld_fire;
    logic            w_cpu_st;
    logic            w_io_wr;
    logic            w_ram_wr;
    logic [15:0]     w_din;

    assign w_ld_fire = ld_valid & (r_state == S_LOAD);
    assign w_cpu_st  = r_run & cpu_wr & ~cpu_addr_mode;
    assign w_io_wr   = w_cpu_st & (cpu_addr == IO_OUT_ADDR);
    assign w_ram_wr  = w_cpu_st & (cpu_addr != IO_OUT_ADDR)
                     & (cpu_addr != IO_IN_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_LOAD;
            r_ptr      <= '0;
            r_cnt      <= HOLD_INIT;
            r_cpu_rst  <= 1'b1;
            r_ld_ready <= 1'b1;
            r_run      <= 1'b0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    if (w_ld_fire) begin
                        // The top word is always the final one; ptr saturates.
                        if (ld_last || r_ptr == PTR_MAX) begin
                            r_state    <= S_HOLD;
                            r_ld_ready <= 1'b0;
                            r_cnt      <= HOLD_INIT;
                        end
                        if (r_ptr != PTR_MAX)
                            r_ptr <= r_ptr + AW'(1);
                    end
                end
                S_HOLD: begin
                    if (r_cnt <= CW'(1)) begin
                        r_state   <= S_RUN;
                        r_cpu_rst <= 1'b0;
                        r_run     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_RUN: ;
                default: r_state <= S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_io_wr;
            if (w_io_wr)
                r_led <= cpu_dout;
        end
    end

    // Store contents survive reset on purpose: no reset branch here.
    always_ff @(posedge clk) begin
        if (w_ld_fire)
            r_mem[r_ptr] <= ld_data;
        else if (w_ram_wr)
            r_mem[cpu_addr] <= cpu_dout;
    end

    always_comb begin
        w_din = r_mem[cpu_addr];
        if (cpu_addr_mode)
            w_din = {{(16-AW){1'b0}}, cpu_addr};
        else if (cpu_addr == IO_IN_ADDR)
            w_din = sw_in;
        else if (cpu_addr == IO_OUT_ADDR)
            w_din = r_led;
    end

    assign cpu_din    = w_din;
    assign cpu_rst    = r_cpu_rst;
    assign ld_ready   = r_ld_ready;
    assign run        = r_run;
    assign led_out    = r_led;
    assign led_strobe = r_strobe;

endmodule

// File: tb/tb_cpu_mem_sys.sv
// Scoreboard bench for cpu_mem_sys: stimulus queues expectations,
// a negedge monitor drains and compares them against the DUT outputs.
module tb_cpu_mem_sys;

  localparam int SEL_DIN  = 0;
  localparam int SEL_LED  = 1;
  localparam int SEL_STB  = 2;
  localparam int SEL_RUN  = 3;
  localparam int SEL_CRST = 4;
  localparam int SEL_RDY  = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } chk_t;

  logic        clk;
  logic        rst_n;
  logic [9:0]  cpu_addr;
  logic        cpu_wr;
  logic        cpu_addr_mode;
  logic [15:0] cpu_dout;
  logic [15:0] cpu_din;
  logic        cpu_rst;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        led_strobe;
  logic        run;

  chk_t q[$];
  int   checks;
  int   failures;

  cpu_mem_sys dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_addr      (cpu_addr),
    .cpu_wr        (cpu_wr),
    .cpu_addr_mode (cpu_addr_mode),
    .cpu_dout      (cpu_dout),
    .cpu_din       (cpu_din),
    .cpu_rst       (cpu_rst),
    .ld_valid      (ld_valid),
    .ld_data       (ld_data),
    .ld_last       (ld_last),
    .ld_ready      (ld_ready),
    .sw_in         (sw_in),
    .led_out       (led_out),
    .led_strobe    (led_strobe),
    .run           (run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] actual(input int sel);
    case (sel)
      SEL_DIN:  return cpu_din;
      SEL_LED:  return led_out;
      SEL_STB:  return {15'd0, led_strobe};
      SEL_RUN:  return {15'd0, run};
      SEL_CRST: return {15'd0, cpu_rst};
      default:  return {15'd0, ld_ready};
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [15:0] a;
      c = q.pop_front();
      a = actual(c.sel);
      checks++;
      if (a !== c.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h at %0t",
                 c.name, a, c.exp, $time);
      end
    end
  end

  task automatic expect_v(input string n, input int s,
                          input logic [15:0] e);
    chk_t c;
    c.name = n;
    c.sel  = s;
    c.exp  = e;
    q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic read_chk(input string n, input logic [9:0] a,
                          input logic [15:0] e);
    cpu_addr = a;
    expect_v(n, SEL_DIN, e);
    step();
  endtask

  task automatic wait_run();
    for (int i = 0; i < 20 && !run; i++)
      step();
    checks++;
    if (run !== 1'b1) begin
      failures++;
      $display("FAIL wait_run: timeout at %0t", $time);
    end
    expect_v("wait_run", SEL_RUN, 16'd1);
    step();
  endtask

  task automatic ld_word(input logic [15:0] d, input logic l);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = l;
    expect_v("ld_ready_load", SEL_RDY, 16'd1);
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic store(input logic [9:0] a, input logic [15:0] d);
    cpu_addr = a;
    cpu_dout = d;
    cpu_wr   = 1'b1;
    step();
    cpu_wr   = 1'b0;
  endtask

  initial begin
    logic [15:0] bdat [4];
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    cpu_addr      = '0;
    cpu_wr        = 1'b0;
    cpu_addr_mode = 1'b0;
    cpu_dout      = '0;
    ld_valid      = 1'b0;
    ld_data       = '0;
    ld_last       = 1'b0;
    sw_in         = 16'hCAFE;

    step();
    checks++;
    if (cpu_rst !== 1'b1 || ld_ready !== 1'b1 || run !== 1'b0
        || led_out !== 16'h0000 || led_strobe !== 1'b0) begin
      failures++;
      $display("FAIL rst_state: crst=%b rdy=%b run=%b led=%h stb=%b",
               cpu_rst, ld_ready, run, led_out, led_strobe);
    end
    expect_v("rst_cpu_rst", SEL_CRST, 16'd1);
    expect_v("rst_ld_ready", SEL_RDY, 16'd1);
    expect_v("rst_run", SEL_RUN, 16'd0);
    expect_v("rst_led", SEL_LED, 16'h0000);
    expect_v("rst_strobe", SEL_STB, 16'd0);
    step();
    rst_n = 1'b1;

    ld_valid = 1'b1;
    ld_data  = 16'h1001;
    expect_v("t1_rdy0", SEL_RDY, 16'd1);
    step();
    ld_data  = 16'h2002;
    expect_v("t1_rdy1", SEL_RDY, 16'd1);
    step();
    ld_data  = 16'h3003;
    ld_last  = 1'b1;
    expect_v("t1_rdy2", SEL_RDY, 16'd1);
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    expect_v("t1_hold_rdy", SEL_RDY, 16'd0);
    expect_v("t1_hold_crst", SEL_CRST, 16'd1);
    expect_v("t1_hold_run", SEL_RUN, 16'd0);
    step();
    expect_v("t1_hold2_run", SEL_RUN, 16'd0);
    expect_v("t1_hold2_crst", SEL_CRST, 16'd1);
    step();
    expect_v("t1_run", SEL_RUN, 16'd1);
    expect_v("t1_run_crst", SEL_CRST, 16'd0);
    expect_v("t1_run_rdy", SEL_RDY, 16'd0);
    step();
    read_chk("t1_rd1", 10'd1, 16'h2002);
    read_chk("t1_rd0", 10'd0, 16'h1001);
    read_chk("t1_rd2", 10'd2, 16'h3003);

    do_reset();
    bdat[0] = 16'hA000;
    bdat[1] = 16'hA111;
    bdat[2] = 16'hA222;
    bdat[3] = 16'hA333;
    for (int w = 0; w < 4; w++) begin
      for (int g = 0; g < w; g++) begin
        expect_v("t2_gap_rdy", SEL_RDY, 16'd1);
        step();
      end
      ld_word(bdat[w], w == 3);
    end
    wait_run();
    for (int w = 0; w < 4; w++)
      read_chk("t2_rd", 10'(w), bdat[w]);

    do_reset();
    for (int i = 0; i < 1024; i++)
      ld_word(16'(i) ^ 16'h5A5A, 1'b0);
    ld_valid = 1'b1;
    ld_data  = 16'hFFFF;
    expect_v("t3_1025_rdy", SEL_RDY, 16'd0);
    step();
    ld_valid = 1'b0;
    wait_run();
    read_chk("t3_rd0", 10'd0, 16'h5A5A);
    read_chk("t3_rd3fd", 10'h3FD, 16'h5A5A ^ 16'h03FD);
    read_chk("t3_rd155", 10'h155, 16'h5B0F);

    cpu_addr = 10'h3FF;
    expect_v("t4_pre_strobe", SEL_STB, 16'd0);
    store(10'h3FF, 16'hBEEF);
    expect_v("t4_led", SEL_LED, 16'hBEEF);
    expect_v("t4_strobe", SEL_STB, 16'd1);
    expect_v("t4_rd3ff", SEL_DIN, 16'hBEEF);
    step();
    expect_v("t4_strobe_off", SEL_STB, 16'd0);
    read_chk("t4_rd3fd", 10'h3FD, 16'h5A5A ^ 16'h03FD);

    cpu_addr = 10'h3FF;
    cpu_wr   = 1'b1;
    cpu_dout = 16'h1111;
    step();
    cpu_dout = 16'h00FF;
    expect_v("t4_b2b_stb1", SEL_STB, 16'd1);
    expect_v("t4_b2b_led1", SEL_LED, 16'h1111);
    step();
    cpu_wr = 1'b0;
    expect_v("t4_b2b_stb2", SEL_STB, 16'd1);
    expect_v("t4_b2b_led2", SEL_LED, 16'h00FF);
    step();
    expect_v("t4_b2b_stb3", SEL_STB, 16'd0);

    store(10'h3FE, 16'h1234);
    expect_v("t4_in_led", SEL_LED, 16'h00FF);
    expect_v("t4_in_stb", SEL_STB, 16'd0);
    expect_v("t4_in_rd", SEL_DIN, 16'hCAFE);
    step();
    store(10'h005, 16'h7777);
    expect_v("t4_ram_rd", SEL_DIN, 16'h7777);
    expect_v("t4_ram_stb", SEL_STB, 16'd0);
    step();

    cpu_addr_mode = 1'b1;
    cpu_addr      = 10'h155;
    cpu_dout      = 16'h9999;
    cpu_wr        = 1'b1;
    expect_v("t5_imm", SEL_DIN, 16'h0155);
    step();
    cpu_wr        = 1'b0;
    cpu_addr_mode = 1'b0;
    expect_v("t5_nowr", SEL_DIN, 16'h5B0F);
    expect_v("t5_strobe", SEL_STB, 16'd0);
    step();

    cpu_addr = 10'd0;
    #2;
    rst_n = 1'b0;
    expect_v("t6_crst", SEL_CRST, 16'd1);
    expect_v("t6_rdy", SEL_RDY, 16'd1);
    expect_v("t6_led", SEL_LED, 16'h0000);
    expect_v("t6_run", SEL_RUN, 16'd0);
    expect_v("t6_rd0", SEL_DIN, 16'h5A5A);
    step();
    rst_n = 1'b1;
    step();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
